// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit MIPS div/divu (remainder -> HI, quotient -> LO), radix-2 restoring.
// Optional DIV_ZERO_EARLY_EN: a zero divisor skips the iteration phase.
//------------------------------------------------------------------------------
// Module   : div_unit
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        we_o,
  output logic        busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] C_LAST_ITER = 6'd32;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [31:0] r_op1_raw;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_we;
  logic        r_busy;

  logic        w_accept;
  logic        w_finish;
  logic        w_iterate;
  logic        w_busy_nxt;
  logic        w_we_nxt;
  logic        w_op1_neg;
  logic        w_op2_neg;
  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;

  assign w_accept = start_i & ~annul_i & ((r_state == S_IDLE) | (r_state == S_DONE));

`ifdef DIV_ZERO_EARLY_EN
  assign w_finish = (r_cnt == C_LAST_ITER) | r_div_zero;
`else
  assign w_finish = (r_cnt == C_LAST_ITER);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (annul_i)       w_next_state = S_IDLE;
        else if (w_finish) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = w_accept ? S_RUN : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_busy_nxt = (w_next_state == S_RUN);
    w_we_nxt   = (r_state == S_RUN) & (w_next_state == S_DONE);
    w_iterate  = (r_state == S_RUN) & ~w_finish;
  end

  assign w_op1_neg = signed_i & opdata1_i[31];
  assign w_op2_neg = signed_i & opdata2_i[31];
  assign w_op1_mag = w_op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_op2_mag = w_op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

  // The remainder stays below the divisor, so the 33-bit difference sign is the quotient bit.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign w_qbit  = ~w_diff[32];

  // 0x8000_0000 / -1 falls out naturally: negating 0x8000_0000 yields itself.
  assign w_quo_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
  assign w_rem_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;
  assign w_hi_res  = r_div_zero ? r_op1_raw : w_rem_fix;
  assign w_lo_res  = r_div_zero ? 32'hFFFF_FFFF : w_quo_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 6'd0;
      r_quo      <= 32'd0;
      r_rem      <= 32'd0;
      r_divisor  <= 32'd0;
      r_op1_raw  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= 6'd0;
      r_quo      <= w_op1_mag;
      r_rem      <= 32'd0;
      r_divisor  <= w_op2_mag;
      r_op1_raw  <= opdata1_i;
      r_neg_q    <= w_op1_neg ^ w_op2_neg;
      r_neg_r    <= w_op1_neg;
      r_div_zero <= (opdata2_i == 32'd0);
    end else if (w_iterate) begin
      r_cnt <= r_cnt + 6'd1;
      r_quo <= {r_quo[30:0], w_qbit};
      r_rem <= w_qbit ? w_diff[31:0] : w_shift[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_we   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_we   <= w_we_nxt;
      r_busy <= w_busy_nxt;
      if (w_we_nxt) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end
  end

  assign hi_o   = r_hi;
  assign lo_o   = r_lo;
  assign we_o   = r_we;
  assign busy_o = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and directed checks of div_unit with a result scoreboard.
//------------------------------------------------------------------------------
// Module   : tb_div_unit
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        annul_i = 1'b0;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        we_o;
  logic        busy_o;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .we_o      (we_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  localparam int NVEC = 12;

  vec_t vecs [NVEC];
  res_t sbq [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      r.hi = a;
      r.lo = 32'hFFFF_FFFF;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.hi = 32'd0;
      r.lo = 32'h8000_0000;
    end else if (sgn) begin
      r.lo = sa / sb;
      r.hi = sa % sb;
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  function automatic int lat(input logic [31:0] b);
`ifdef DIV_ZERO_EARLY_EN
    return (b == 32'd0) ? 1 : 33;
`else
    return (b == 32'd0) ? 33 : 33;
`endif
  endfunction

  // Scoreboard: every write pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (rst && we_o) begin
      chk("we_consecutive", {31'd0, prev_we}, 32'd0);
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: hi=%h lo=%h with no operation outstanding", hi_o, lo_o);
      end else begin
        res_t r;
        r = sbq.pop_front();
        chk("sb_hi", hi_o, r.hi);
        chk("sb_lo", lo_o, r.lo);
      end
    end
    prev_we <= we_o;
  end

  // Drive a start for one edge; called just after a falling edge.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    res_t r;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    if (push) begin
      r.hi = eh;
      r.lo = el;
      sbq.push_back(r);
    end
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Returns on the falling edge of the write cycle.
  task automatic wait_done(input int exp_lat, input string tag);
    int  n;
    int  bcnt;
    bit  seen;
    logic busy_at_we;
    n = -1;
    bcnt = 0;
    seen = 1'b0;
    busy_at_we = 1'b1;
    for (int k = 0; k < 45 && !seen; k++) begin
      @(negedge clk);
      if (we_o) begin
        seen = 1'b1;
        n = k;
        busy_at_we = busy_o;
      end else if (busy_o) begin
        bcnt++;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no write within 45 cycles, expected at %0d", tag, exp_lat);
    end else begin
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_busy_cycles"}, bcnt, exp_lat);
      chk({tag, "_busy_at_we"}, {31'd0, busy_at_we}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_hi;
    logic [31:0] last_lo;
    res_t r;

    vecs[0]  = '{1'b0, 32'd100,         32'd7,           32'd2,           32'd14};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   32'hFFFF_FFFD};
    vecs[2]  = '{1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           32'h8000_0000};
    vecs[3]  = '{1'b0, 32'd1234,        32'd0,           32'd1234,        32'hFFFF_FFFF};
    vecs[4]  = '{1'b1, 32'hFFFF_FF9C,   32'd0,           32'hFFFF_FF9C,   32'hFFFF_FFFF};
    vecs[5]  = '{1'b1, 32'd100,         32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFF2};
    vecs[6]  = '{1'b1, 32'hFFFF_FF9C,   32'hFFFF_FFF9,   32'hFFFF_FFFE,   32'd14};
    vecs[7]  = '{1'b0, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   32'd0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,   32'd1,           32'd0,           32'hFFFF_FFFF};
    vecs[9]  = '{1'b0, 32'd7,           32'd100,         32'd7,           32'd0};
    vecs[10] = '{1'b1, 32'h8000_0000,   32'd1,           32'd0,           32'h8000_0000};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'd0,           32'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
      wait_done(lat(vecs[i].b), $sformatf("vec%0d", i));
    end
    last_hi = vecs[NVEC-1].hi;
    last_lo = vecs[NVEC-1].lo;

    // Annul while idle blocks the start
    @(negedge clk);
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    chk("annul_idle_busy", {31'd0, busy_o}, 32'd0);

    // Annul at iteration 10: no write, results held, restart next cycle
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0;
    chk("annul_run_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk("annul_hold_hi", hi_o, last_hi);
    chk("annul_hold_lo", lo_o, last_lo);
    r = model(1'b0, 32'd999, 32'd10);
    issue(1'b0, 32'd999, 32'd10, r.hi, r.lo, 1'b1);
    wait_done(33, "after_annul");

    // Back-to-back: second start during the first write cycle
    @(negedge clk);
    issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done(33, "b2b_first");
    issue(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b1);
    wait_done(33, "b2b_second");

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      r = model(sgn, a, b);
      @(negedge clk);
      issue(sgn, a, b, r.hi, r.lo, 1'b1);
      wait_done(lat(b), $sformatf("rand%0d", i));
    end

    // Asynchronous reset at iteration 20
    @(negedge clk);
    issue(1'b0, 32'd77, 32'd5, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    issue(1'b0, 32'd50000, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    chk("midrst_we", {31'd0, we_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    wait_done(33, "after_rst");

    repeat (40) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that produces the HI/LO write for MIPS `div`/`divu`: remainder to HI, quotient to LO. It sits beside the execute stage, stalls the pipeline through `busy_o` while iterating, and drives the HI/LO register's write port (`we`, `hi_i`, `lo_i`) with a one-cycle write pulse per completed division.

## Interface
- No parameters; data width fixed at 32 bits.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start_i` in 1: request a division; sampled only in IDLE or DONE.
- `signed_i` in 1: 1 = `div` (two's complement), 0 = `divu`; sampled with `start_i`.
- `opdata1_i` in 32: dividend; sampled with `start_i`.
- `opdata2_i` in 32: divisor; sampled with `start_i`.
- `annul_i` in 1: flush; cancels an in-flight division.
- `hi_o` out 32: remainder; to HI/LO register `hi_i`.
- `lo_o` out 32: quotient; to HI/LO register `lo_i`.
- `we_o` out 1: HI/LO write enable; one-cycle pulse.
- `busy_o` out 1: stall request to pipeline control.

## Operation
- States: IDLE, RUN, DONE. Iteration counter: 6 bits, 0..32.
- Operands are latched when `start_i`=1 and `annul_i`=0 in IDLE or DONE. If `signed_i`=1, magnitudes are latched and the sign of each operand is recorded. Next state is RUN with counter 0.
- RUN: radix-2 restoring division on 32-bit magnitudes, one quotient bit per cycle, MSB first, with a 33-bit partial remainder. After 32 iterations the next state is DONE.
- Entering DONE registers the sign-corrected results into `hi_o`/`lo_o` and sets `we_o`=1.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned: results are the raw magnitudes.
- DONE lasts exactly one cycle. Next state is RUN if a new start is accepted, otherwise IDLE.
- Divide by zero (`opdata2_i`=0), either signedness: `hi_o` = `opdata1_i` as given, `lo_o` = 32'hFFFF_FFFF.
- Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF: `lo_o` = 32'h8000_0000, `hi_o` = 0.
- `annul_i`=1 in RUN: next state is IDLE, no `we_o`, `hi_o`/`lo_o` keep their previous values.
- `annul_i` in IDLE or DONE blocks start acceptance only. It does not retract a `we_o` already asserted.
- `start_i` during RUN is ignored.
- `hi_o`/`lo_o` hold the last result until the next DONE.

## Timing
- Reset (rst=0), effective immediately and asynchronously: state IDLE; `hi_o`, `lo_o` = 32'h0; `we_o`=0; `busy_o`=0; counter 0. A reset during RUN discards the operation.
- Start accepted at edge E0: `busy_o`=1 from E0 through E33.
- Iterations occur at edges E1..E32.
- At E33: state DONE, `we_o`=1, results valid, `busy_o`=0.
- At E34: `we_o`=0.
- Latency is 33 cycles from start to write. Pipeline control releases the stall in the same cycle the write occurs.
- Back-to-back: a start accepted in the DONE cycle keeps `we_o` for the old result for exactly that one cycle, then `busy_o`=1 for the new operation.
- `we_o` is never high for two consecutive cycles.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `DIV_ZERO_EARLY_EN` defined: a zero divisor skips RUN. Start at E0 goes to DONE at E1 with `we_o`=1, and `busy_o` is high for one cycle.
- `DIV_ZERO_EARLY_EN` undefined: a zero divisor takes the full 33-cycle path.
- Result values are identical in both builds.

## Test plan
- **Unsigned divide:** `divu` 100/7 → at start+33, `we_o` pulses once with `lo_o`=14, `hi_o`=2. `busy_o` is high for exactly 33 cycles.
- **Signed divide:** `div` −7/2 (32'hFFFF_FFF9 / 2) → `lo_o`=32'hFFFF_FFFD, `hi_o`=32'hFFFF_FFFF.
- **Signed overflow:** `div` 32'h8000_0000 / 32'hFFFF_FFFF → `lo_o`=32'h8000_0000, `hi_o`=0.
- **Divide by zero:** 1234/0 → `hi_o`=1234, `lo_o`=32'hFFFF_FFFF. Write occurs at start+1 with the macro defined, start+33 without.
- **Annul and reset mid-operation:** `annul_i` at iteration 10 → no `we_o`, prior `hi_o`/`lo_o` unchanged, next start accepted one cycle later. Asserting `rst` low at iteration 20 → all outputs 0 immediately.
- **Back-to-back:** second start (9/3) in the DONE cycle of the first (100/7) → two single-cycle `we_o` pulses 33 cycles apart, with results 14/2 then 3/0.
